int_to_fp_conv: RTL and testbench
=================================

Name: int_to_fp_conv

Overview:
- Multi-cycle converter from 32-bit two's-complement integer to IEEE-754 single-precision (seee_eeee_emmm_mmmm_mmmm_mmmm_mmmm_mmmm).
- Produces the FP operands consumed by FP_adder and the other FP datapath blocks, e.g. feeding integer pixel sums and counters into the recognition network.
- Normalizes iteratively, one left shift per clock, then rounds to nearest-even.
- Uses a strt/done handshake.

Parameters:
- BIAS, 127, exponent bias.
- EXP_INIT, 158, initial exponent (BIAS+31) loaded before normalization.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- strt  input  1  start request; sampled only in IDLE.
- in_int  input  32  signed integer operand; sampled with strt.
- busy  output  1  high while a conversion is in progress (NORM or ROUND).
- done  output  1  one-cycle pulse; fp_out is valid from this cycle.
- fp_out  output  32  FP result; held until the next done.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, fp_out=32'h0000_0000, internal mag/exp/sign cleared.
- States: IDLE, NORM, ROUND.
- IDLE:
  - On strt=1 at a clock edge: sign <= in_int[31]; mag <= |in_int| as 32-bit unsigned (32'h8000_0000 stays 32'h8000_0000); exp <= EXP_INIT; go to NORM.
  - strt=0: remain in IDLE.
- NORM:
  - If mag==0 or mag[31]==1: go to ROUND.
  - Else: mag <= mag<<1, exp <= exp-1, stay in NORM.
  - At most 31 shifts.
- ROUND, exit edge registers fp_out, pulses done=1 and returns to IDLE:
  - Zero case: mag==0 gives fp_out=32'h0 (no negative zero).
  - Fields: M=mag[30:8], L=mag[8], G=mag[7], S=|mag[6:0].
  - Round up iff G & (S | L).
  - Round up with M==23'h7FFFFF: M becomes 0 and exp increments.
  - fp_out = {sign, exp, M}.
  - Exponent cannot overflow: max 159.
- done:
  - Registered; high exactly one cycle.
  - Low in every cycle except the one following the ROUND exit edge.
- busy: high exactly while state is NORM or ROUND.
- Latency: lz = leading-zero count of mag at capture (0 for zero input and for 32'h8000_0000). done is high in the cycle after edge E0+lz+2, where E0 is the edge that samples strt. Range 2..33 clocks.
- Back-to-back: strt asserted in the cycle where done=1 is accepted (state is already IDLE). No idle gap is required.
- strt while busy: ignored. The in-flight conversion is unaffected and in_int changes are not captured.
- in_int may change freely after the sampling edge.
- Reset mid-conversion: immediate return to IDLE with all outputs at reset values. No done pulse for the aborted operation.
- Throughput: one conversion in flight. No queueing.

Test Plan:
- Reset then strt with in_int=32'h0000_0001 -> done 33 clocks after the sampling edge, fp_out=32'h3F80_0000; busy high for 33 cycles.
- in_int=32'hFFFF_FFFF (-1) -> fp_out=32'hBF80_0000. in_int=0 -> done after 2 clocks, fp_out=32'h0000_0000.
- in_int=32'h8000_0000 -> done after 2 clocks, fp_out=32'hCF00_0000. in_int=32'h7FFF_FFFF -> mantissa round-up overflow, fp_out=32'h4F00_0000.
- Rounding cases:
  - in_int=16777217 -> tie, round to even, fp_out=32'h4B80_0000.
  - in_int=16777219 -> tie, round up, fp_out=32'h4B80_0002.
  - in_int=-100 -> fp_out=32'hC2C8_0000.
- Handshake:
  - strt pulsed with 5 during the busy conversion of 1 -> ignored; only one done, fp_out=32'h3F80_0000.
  - strt with 3 in the done cycle -> accepted; fp_out=32'h4040_0000 at the next done.
- Async rst asserted mid-NORM (not on a clock edge) -> outputs return to 0 immediately, no done. A fresh strt with 2 then yields fp_out=32'h4000_0000.

Source files
------------

// File: rtl/int_to_fp_conv.sv
// Multi-cycle 32-bit signed integer to IEEE-754 single-precision converter.
// Normalizes with one left shift per clock, then rounds to nearest-even.
//
// state | meaning
// IDLE  | waiting for strt, fp_out holds the last result
// NORM  | shifting mag left until bit 31 is set (or mag is zero)
// ROUND | round-to-nearest-even, register fp_out, pulse done
module int_to_fp_conv #(
  parameter int unsigned BIAS     = 127,
  parameter int unsigned EXP_INIT = BIAS + 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt,
  input  logic [31:0] in_int,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_e;

  localparam logic [7:0] EXP_START = 8'(EXP_INIT);

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] fp_q, fp_d;
  logic        done_q, done_d;

  logic        rnd_up;
  logic [23:0] man_sum;
  logic [7:0]  exp_rnd;
  logic [31:0] fp_rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= 32'h0;
      exp_q   <= 8'h0;
      sign_q  <= 1'b0;
      fp_q    <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      fp_q    <= fp_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (strt) begin
          sign_d  = in_int[31];
          // Negating 32'h8000_0000 wraps back to itself, which is the right magnitude.
          mag_d   = in_int[31] ? (~in_int + 32'd1) : in_int;
          exp_d   = EXP_START;
          state_d = NORM;
        end
      end
      NORM: begin
        if ((mag_q == 32'h0) || mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == NORM) || (state_q == ROUND);
    rnd_up  = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    // A carry out of the mantissa leaves it zero and bumps the exponent.
    man_sum = {1'b0, mag_q[30:8]} + {23'h0, rnd_up};
    exp_rnd = exp_q + {7'h0, man_sum[23]};
    fp_rnd  = (mag_q == 32'h0) ? 32'h0 : {sign_q, exp_rnd, man_sum[22:0]};
    done_d  = (state_q == ROUND);
    fp_d    = (state_q == ROUND) ? fp_rnd : fp_q;
  end

  assign done   = done_q;
  assign fp_out = fp_q;

endmodule

// File: tb/tb_int_to_fp_conv.sv
// Randomized self-checking bench for int_to_fp_conv against an arithmetic reference model.
module tb_int_to_fp_conv;

  logic        clk;
  logic        rst;
  logic        strt;
  logic [31:0] in_int;
  logic        busy;
  logic        done;
  logic [31:0] fp_out;

  int n_checks = 0;
  int n_errors = 0;

  int_to_fp_conv dut (
    .clk    (clk),
    .rst    (rst),
    .strt   (strt),
    .in_int (in_int),
    .busy   (busy),
    .done   (done),
    .fp_out (fp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: highest set bit of |x|, explicit round-half-even on the discarded bits.
  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    longint v, mag, q, rem, half;
    int p, sh, e;
    if (x == 32'h0) return 32'h0;
    v   = longint'($signed(x));
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 33; i++) if (mag >= (64'sd1 <<< i)) p = i;
    if (p <= 23) begin
      q = mag <<< (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >>> sh;
      rem  = mag - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if ((rem > half) || ((rem == half) && (q % 2 == 1))) q = q + 1;
    end
    e = 127 + p;
    if (q == (64'sd1 <<< 24)) begin
      q = q >>> 1;
      e = e + 1;
    end
    return {x[31], 8'(e), q[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] x);
    logic [31:0] m;
    int lz;
    m = x[31] ? (32'h0 - x) : x;
    if (m == 32'h0) return 2;
    lz = 0;
    while (m[31 - lz] == 1'b0) lz++;
    return lz + 2;
  endfunction

  task automatic start(input logic [31:0] x);
    @(negedge clk);
    strt   = 1'b1;
    in_int = x;
    @(posedge clk);
    #1;
    strt   = 1'b0;
    in_int = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    if (busy) busy_n++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_n++;
    end
    if (lat == 0) chk("done_timeout", 32'(lat), 32'(1));
  endtask

  task automatic conv(input string tag, input logic [31:0] x);
    int lat, busy_n;
    start(x);
    wait_done(lat, busy_n);
    chk({tag, "_fp"}, fp_out, ref_fp(x));
    chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(x)));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(ref_lat(x)));
    chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, {31'h0, done}, 32'h0);
    chk({tag, "_fp_hold"}, fp_out, ref_fp(x));
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  initial begin
    int lat, busy_n, nd;
    logic [31:0] x;

    rst    = 1'b1;
    strt   = 1'b0;
    in_int = 32'h0;
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_fp", fp_out, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed values, each compared to both the model and a literal.
    conv("one", 32'h0000_0001);
    chk("one_const", fp_out, 32'h3F80_0000);
    conv("minus_one", 32'hFFFF_FFFF);
    chk("minus_one_const", fp_out, 32'hBF80_0000);
    conv("zero", 32'h0);
    chk("zero_const", fp_out, 32'h0);
    conv("int_min", 32'h8000_0000);
    chk("int_min_const", fp_out, 32'hCF00_0000);
    conv("int_max", 32'h7FFF_FFFF);
    chk("int_max_const", fp_out, 32'h4F00_0000);
    conv("tie_even", 32'd16777217);
    chk("tie_even_const", fp_out, 32'h4B80_0000);
    conv("tie_up", 32'd16777219);
    chk("tie_up_const", fp_out, 32'h4B80_0002);
    conv("minus_100", 32'hFFFF_FF9C);
    chk("minus_100_const", fp_out, 32'hC2C8_0000);

    // strt while busy must be ignored.
    start(32'h1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        strt   = 1'b1;
        in_int = 32'd5;
      end
      if (i == 4) strt = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ignore_lat", 32'(lat), 32'd33);
    chk("ignore_fp", fp_out, 32'h3F80_0000);
    count_dones(40, nd);
    chk("ignore_extra_done", 32'(nd), 32'd0);

    // Back-to-back: strt in the done cycle.
    start(32'h1);
    wait_done(lat, busy_n);
    chk("b2b_first_fp", fp_out, 32'h3F80_0000);
    strt   = 1'b1;
    in_int = 32'd3;
    @(posedge clk);
    #1;
    strt = 1'b0;
    wait_done(lat, busy_n);
    chk("b2b_second_lat", 32'(lat), 32'd32);
    chk("b2b_second_fp", fp_out, 32'h4040_0000);

    // Asynchronous reset in the middle of NORM, away from any clock edge.
    start(32'h1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_fp", fp_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(40, nd);
    chk("arst_no_done", 32'(nd), 32'd0);
    conv("after_arst", 32'd2);
    chk("after_arst_const", fp_out, 32'h4000_0000);

    // Random operands spread over all leading-zero counts and both signs.
    for (int k = 0; k < 150; k++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = 32'h0 - x;
      conv("rand", x);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
